// File: rtl/branch_pred_btb.sv
// rtl/branch_pred_btb.sv - fully-associative BTB with per-entry 2-bit direction counters
// Optional same-cycle update-to-lookup forwarding: define PRED_FWD_EN.
module branch_pred_btb #(
    parameter int XLEN           = 32,
    parameter int PRED_WPTR_SIZE = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            pred_hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_next_pc_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int ENTRIES = 1 << PRED_WPTR_SIZE;
    localparam int TAGW    = XLEN - 2;

    localparam logic [1:0] PRED_SNT = 2'b00;
    localparam logic [1:0] PRED_WT  = 2'b10;
    localparam logic [1:0] PRED_ST  = 2'b11;

    logic                      valid_q  [ENTRIES];
    logic [TAGW-1:0]           tag_q    [ENTRIES];
    logic [XLEN-1:0]           target_q [ENTRIES];
    logic [1:0]                ctr_q    [ENTRIES];
    logic [PRED_WPTR_SIZE-1:0] wptr_q;

    logic [ENTRIES-1:0]        lk_match;
    logic [ENTRIES-1:0]        up_match;
    logic [PRED_WPTR_SIZE-1:0] lk_idx;
    logic [PRED_WPTR_SIZE-1:0] up_idx;
    logic                      up_hit;
    logic [1:0]                up_ctr_nxt;
    logic                      lk_hit;
    logic [1:0]                lk_ctr;
    logic [XLEN-1:0]           lk_target;
    logic [1:0]                unused_pc_lsb;

    assign unused_pc_lsb = upd_pc_i[1:0];

    // Tags are unique by construction, so a simple index search suffices.
    always_comb begin
        lk_match = '0;
        up_match = '0;
        lk_idx   = '0;
        up_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            lk_match[i] = valid_q[i] && (tag_q[i] == if_pc_i[XLEN-1:2]);
            up_match[i] = valid_q[i] && (tag_q[i] == upd_pc_i[XLEN-1:2]);
            if (lk_match[i]) lk_idx = i[PRED_WPTR_SIZE-1:0];
            if (up_match[i]) up_idx = i[PRED_WPTR_SIZE-1:0];
        end
    end

    assign up_hit = |up_match;

    always_comb begin
        up_ctr_nxt = ctr_q[up_idx];
        if (upd_taken_i) begin
            if (ctr_q[up_idx] != PRED_ST) up_ctr_nxt = ctr_q[up_idx] + 2'd1;
        end else begin
            if (ctr_q[up_idx] != PRED_SNT) up_ctr_nxt = ctr_q[up_idx] - 2'd1;
        end
    end

    always_comb begin
        lk_hit    = |lk_match;
        lk_ctr    = ctr_q[lk_idx];
        lk_target = target_q[lk_idx];
`ifdef PRED_FWD_EN
        // Present the state the entry will hold after this edge.
        if (upd_valid_i && (upd_pc_i[XLEN-1:2] == if_pc_i[XLEN-1:2])) begin
            if (up_hit) begin
                lk_hit = 1'b1;
                lk_ctr = up_ctr_nxt;
                if (upd_taken_i) lk_target = upd_target_i;
            end else if (upd_taken_i) begin
                lk_hit    = 1'b1;
                lk_ctr    = PRED_WT;
                lk_target = upd_target_i;
            end
        end
`endif
    end

    assign pred_hit_o     = lk_hit;
    assign pred_taken_o   = lk_hit & lk_ctr[1];
    assign pred_next_pc_o = pred_taken_o ? lk_target : if_pc_i + XLEN'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= PRED_SNT;
            end
            wptr_q <= '0;
        end else if (upd_valid_i) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_nxt;
                if (upd_taken_i) target_q[up_idx] <= upd_target_i;
            end else if (upd_taken_i) begin
                valid_q[wptr_q]  <= 1'b1;
                tag_q[wptr_q]    <= upd_pc_i[XLEN-1:2];
                target_q[wptr_q] <= upd_target_i;
                ctr_q[wptr_q]    <= PRED_WT;
                wptr_q           <= wptr_q + 1'b1;
            end
        end
    end

    a_lookup_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(lk_match));
    a_update_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(up_match));

endmodule

// File: tb/tb_branch_pred_btb.sv
// tb/tb_branch_pred_btb.sv - directed self-checking bench for branch_pred_btb
module tb_branch_pred_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc_i;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_next_pc_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_pred_btb #(.XLEN(32), .PRED_WPTR_SIZE(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc_i        (if_pc_i),
        .pred_hit_o     (pred_hit_o),
        .pred_taken_o   (pred_taken_o),
        .pred_next_pc_o (pred_next_pc_o),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_target_i   (upd_target_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_taken_i  = taken;
        upd_target_i = tgt;
        tick();
        upd_valid_i  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] nxt);
        if_pc_i = pc;
        #1;
        check({tag, ".hit"},   32'(pred_hit_o),   32'(hit));
        check({tag, ".taken"}, 32'(pred_taken_o), 32'(taken));
        check({tag, ".next"},  pred_next_pc_o,    nxt);
    endtask

    initial begin
        reset        = 1'b1;
        if_pc_i      = 32'h100;
        upd_valid_i  = 1'b0;
        upd_pc_i     = 32'h0;
        upd_taken_i  = 1'b0;
        upd_target_i = 32'h0;
        tick();
        tick();
        look("rst", 32'h100, 1'b0, 1'b0, 32'h104);
        reset = 1'b0;
        tick();

        upd(32'h100, 1'b1, 32'h200);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

        // 10 -> 11 -> 11 -> 11, last taken update moves the target
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h204);
        look("sat_up", 32'h100, 1'b1, 1'b1, 32'h204);
        upd(32'h100, 1'b0, 32'h0);
        look("nt1", 32'h100, 1'b1, 1'b1, 32'h204);
        upd(32'h100, 1'b0, 32'h0);
        look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);
        look("nt4", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b1, 32'h208);
        look("sat_dn", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h20C);
        look("recover", 32'h100, 1'b1, 1'b1, 32'h20C);

        // 0x100 in entry 0, wptr=1: 0x10..0x30 fill 1..3, 0x40 -> 0, 0x50 -> 1
        upd(32'h10, 1'b1, 32'h1010);
        upd(32'h20, 1'b1, 32'h1020);
        upd(32'h30, 1'b1, 32'h1030);
        upd(32'h40, 1'b1, 32'h1040);
        upd(32'h50, 1'b1, 32'h1050);
        look("evict10", 32'h10, 1'b0, 1'b0, 32'h14);
        look("new50", 32'h50, 1'b1, 1'b1, 32'h1050);
        look("keep20", 32'h20, 1'b1, 1'b1, 32'h1020);
        look("evict100", 32'h100, 1'b0, 1'b0, 32'h104);

        upd(32'h300, 1'b0, 32'h3000);
        look("ntmiss", 32'h300, 1'b0, 1'b0, 32'h304);
        upd(32'h60, 1'b1, 32'h1060);
        look("wptr_evict20", 32'h20, 1'b0, 1'b0, 32'h24);
        look("wptr_keep30", 32'h30, 1'b1, 1'b1, 32'h1030);

        // update inputs without the strobe must be ignored
        upd_valid_i  = 1'b0;
        upd_pc_i     = 32'h30;
        upd_taken_i  = 1'b0;
        upd_target_i = 32'h0;
        tick();
        tick();
        upd_pc_i    = 32'h700;
        upd_taken_i = 1'b1;
        tick();
        look("novalid30", 32'h30, 1'b1, 1'b1, 32'h1030);
        look("novalid700", 32'h700, 1'b0, 1'b0, 32'h704);

        // same-cycle update and lookup
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h400;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h800;
`ifdef PRED_FWD_EN
        look("same", 32'h400, 1'b1, 1'b1, 32'h800);
`else
        look("same", 32'h400, 1'b0, 1'b0, 32'h404);
`endif
        tick();
        upd_valid_i = 1'b0;
        look("after", 32'h400, 1'b1, 1'b1, 32'h800);

        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // asynchronous reset mid-cycle, with a coinciding update
        reset = 1'b1;
        look("midrst", 32'h50, 1'b0, 1'b0, 32'h54);
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h900;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h990;
        tick();
        tick();
        upd_valid_i = 1'b0;
        reset       = 1'b0;
        look("rstupd", 32'h900, 1'b0, 1'b0, 32'h904);
        look("rst400", 32'h400, 1'b0, 1'b0, 32'h404);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
